lcd_frame_writer: RTL
=====================

Name: lcd_frame_writer

Overview:
Downstream of the pixel FIFO. Consumes the palettized 2-bit pixel stream (pixel + valid, no backpressure) in raster order and packs 4 pixels per byte. Writes the packed bytes into a double-buffered framebuffer RAM through a valid/ready write port. When a full 160x144 frame has been written, it swaps the front bank for the display scan-out side.

Parameters:
H_PIXELS, 160, visible pixels per line
V_PIXELS, 144, visible lines per frame
PIX_PER_WORD, 4, 2-bit pixels packed per 8-bit framebuffer word
WORDS_PER_FRAME, 5760, H_PIXELS*V_PIXELS/PIX_PER_WORD
FB_ADDR_WIDTH, 14, framebuffer word address width (covers 2 banks = 11520 words)
BUF_DEPTH, 4, packed-word buffer entries (power of 2)

Ports:
clk_in  input  1  system clock
rst_in  input  1  asynchronous, active-low reset
lcd_on_in  input  1  LCDC bit 7; low = PPU off
frame_start_in  input  1  one-cycle pulse at start of line 0 from the mode controller
pixel_in  input  2  palettized shade from the pixel FIFO
pixel_valid_in  input  1  pixel_in valid this cycle
fb_addr_out  output  FB_ADDR_WIDTH  framebuffer word address
fb_data_out  output  8  packed word; pixel k of the group in bits [2k+1:2k]
fb_valid_out  output  1  write request
fb_ready_in  input  1  RAM accepts the write when valid && ready
front_bank_out  output  1  bank the display reads
frame_done_out  output  1  one-cycle pulse on bank swap
overflow_out  output  1  sticky; a word or pixel was dropped this frame

Behaviour:
- Reset (rst_in low, async): state IDLE; x/y/word counters 0; buffer empty; fb_valid_out 0; fb_addr_out 0; fb_data_out 0; front_bank_out 0; frame_done_out 0; overflow_out 0. Back bank = !front_bank_out.
- States:
  - IDLE: pixels ignored. Go to ACTIVE on frame_start_in && lcd_on_in.
  - ACTIVE: accept pixels. When the last pixel (x=159, y=143) is accepted, go to DRAIN.
  - DRAIN: wait until the buffer is empty. Then toggle front_bank_out, pulse frame_done_out, and go to IDLE.
- lcd_on_in low in any state:
  - next state IDLE; counters and partial word cleared.
  - Buffered words still drain.
  - No bank swap.
- Pixel accept in ACTIVE, per valid:
  - Shift into the packing register at slot x%4.
  - x increments; at x=159 it wraps to 0 and y increments.
  - Counters are 8-bit; y never exceeds 143.
- Word completion: on the 4th pixel of a group, push {packed byte, address} into the buffer.
  - address = back_bank*WORDS_PER_FRAME + word_cnt; word_cnt increments 0..5759.
  - No multiplier; running counter only.
- Latency: the 4th pixel accepted in cycle N with buffer empty -> fb_valid_out=1 in cycle N+1, showing that word.
  - Outputs are registered from the buffer head.
- Write port:
  - fb_valid_out = buffer non-empty.
  - Head pops on fb_valid_out && fb_ready_in.
  - fb_addr_out/fb_data_out are stable while valid && !ready.
  - A simultaneous push and pop with the buffer full is allowed; no drop.
- Overflow:
  - Word completes while the buffer is full and no pop occurs this cycle -> word dropped, overflow_out=1, counters still advance.
  - pixel_valid_in in IDLE while lcd_on_in=1, or in DRAIN -> pixel ignored, overflow_out=1.
- overflow_out clears only on an accepted frame_start_in or reset.
- frame_start_in in ACTIVE or DRAIN (early restart):
  - Counters and partial word cleared; restart ACTIVE.
  - Bank unchanged, no frame_done_out.
  - Buffered words still drain to their stored addresses.
- frame_start_in and pixel_valid_in in the same cycle: frame_start wins; that pixel is treated as x=0, y=0.
- frame_done_out and frame_start_in in the same cycle: swap completes; the new frame targets the new back bank.

Test Plan:
- Reset, frame_start, 4 pixels 3,2,1,0 with fb_ready_in=1 -> cycle after the 4th pixel: fb_valid_out=1, fb_data_out=8'h1B, fb_addr_out=5760 (back bank 1).
- Full frame of 23040 pixels, fb_ready_in=1 -> 5760 writes at addresses 5760..11519. Then one frame_done_out pulse, front_bank_out 0->1, overflow_out=0. Second frame writes addresses 0..5759.
- fb_ready_in=0 while 20 pixels stream -> 4 words buffered, 5th word dropped, overflow_out=1. Addr/data held stable; with ready=1 the 4 words drain in order.
- frame_start_in mid-frame at word_cnt=100 -> next word written to back_bank base+0; no bank swap; overflow_out cleared.
- lcd_on_in drops during ACTIVE -> IDLE, pending words drain, front_bank_out unchanged. Pixels then ignored until lcd_on_in=1 and frame_start_in.
- rst_in asserted mid-DRAIN with fb_valid_out=1 -> all outputs 0 immediately (async), front_bank_out=0.

Source files
------------

// File: rtl/lcd_frame_writer.sv
// Packs the 2-bit pixel stream four to a byte and writes it into the back
// bank of a double-buffered framebuffer, swapping banks after each frame.
module lcd_frame_writer #(
   parameter int H_PIXELS        = 160,
   parameter int V_PIXELS        = 144,
   parameter int PIX_PER_WORD    = 4,
   parameter int WORDS_PER_FRAME = 5760,
   parameter int FB_ADDR_WIDTH   = 14,
   parameter int BUF_DEPTH       = 4
) (
   input  logic                     clk_in,
   input  logic                     rst_in,
   input  logic                     lcd_on_in,
   input  logic                     frame_start_in,
   input  logic [1:0]               pixel_in,
   input  logic                     pixel_valid_in,
   output logic [FB_ADDR_WIDTH-1:0] fb_addr_out,
   output logic [7:0]               fb_data_out,
   output logic                     fb_valid_out,
   input  logic                     fb_ready_in,
   output logic                     front_bank_out,
   output logic                     frame_done_out,
   output logic                     overflow_out
);

   localparam int AW = FB_ADDR_WIDTH;
   localparam int PW = $clog2(BUF_DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {
      IDLE,
      ACTIVE,
      DRAIN
   } state_t;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [7:0]    data;
   } fb_word_t;

   state_t        state;
   logic [7:0]    x_cnt;
   logic [7:0]    y_cnt;
   logic [5:0]    pack_q;
   logic [AW-1:0] word_addr;

   fb_word_t      buf_q [BUF_DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] cnt_q;

   logic          buf_empty;
   logic          buf_full;
   logic          pop;
   logic          push;
   logic          drop;
   logic          start_ok;
   logic          take_pix;
   logic          word_done;
   logic          last_pix;
   logic          swap;
   logic          stray;
   logic [AW-1:0] base_next;
   logic [PW-1:0] rd_next;
   logic [CW-1:0] cnt_left;
   logic [CW-1:0] cnt_next;
   fb_word_t      new_word;

   always_comb begin
      buf_empty = (cnt_q == '0);
      buf_full  = (cnt_q == CW'(BUF_DEPTH));
      pop       = !buf_empty && fb_ready_in;
      start_ok  = frame_start_in && lcd_on_in;
      take_pix  = (state == ACTIVE) && lcd_on_in
                  && !frame_start_in && pixel_valid_in;
      word_done = take_pix
                  && (x_cnt[1:0] == 2'(PIX_PER_WORD - 1));
      last_pix  = take_pix
                  && (x_cnt == 8'(H_PIXELS - 1))
                  && (y_cnt == 8'(V_PIXELS - 1));
      push      = word_done && (!buf_full || pop);
      drop      = word_done && buf_full && !pop;
      swap      = (state == DRAIN) && lcd_on_in && buf_empty;
      stray     = pixel_valid_in && !start_ok
                  && (((state == IDLE) && lcd_on_in)
                      || (state == DRAIN));
      // a frame starting on the swap cycle targets the bank just vacated
      base_next = (swap ? front_bank_out : !front_bank_out)
                  ? AW'(WORDS_PER_FRAME) : '0;
      new_word  = {word_addr, pixel_in, pack_q};
      rd_next   = rd_ptr + PW'(pop);
      cnt_left  = cnt_q - CW'(pop);
      cnt_next  = cnt_left + CW'(push);
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state          <= IDLE;
         x_cnt          <= '0;
         y_cnt          <= '0;
         pack_q         <= '0;
         word_addr      <= '0;
         front_bank_out <= 1'b0;
         frame_done_out <= 1'b0;
      end else begin
         frame_done_out <= swap;
         if (swap) begin
            front_bank_out <= !front_bank_out;
         end
         if (!lcd_on_in) begin
            state  <= IDLE;
            x_cnt  <= '0;
            y_cnt  <= '0;
            pack_q <= '0;
         end else if (frame_start_in) begin
            state     <= ACTIVE;
            y_cnt     <= '0;
            word_addr <= base_next;
            x_cnt     <= pixel_valid_in ? 8'd1 : 8'd0;
            pack_q    <= {4'b0, pixel_valid_in ? pixel_in : 2'b00};
         end else begin
            unique case (state)
               IDLE: state <= IDLE;
               ACTIVE: begin
                  if (pixel_valid_in) begin
                     case (x_cnt[1:0])
                        2'd0:    pack_q[1:0] <= pixel_in;
                        2'd1:    pack_q[3:2] <= pixel_in;
                        2'd2:    pack_q[5:4] <= pixel_in;
                        default: pack_q      <= pack_q;
                     endcase
                     if (word_done) begin
                        word_addr <= word_addr + AW'(1);
                     end
                     if (x_cnt == 8'(H_PIXELS - 1)) begin
                        x_cnt <= '0;
                        if (y_cnt != 8'(V_PIXELS - 1)) begin
                           y_cnt <= y_cnt + 8'd1;
                        end
                     end else begin
                        x_cnt <= x_cnt + 8'd1;
                     end
                     if (last_pix) begin
                        state <= DRAIN;
                     end
                  end
               end
               DRAIN: begin
                  if (buf_empty) begin
                     state <= IDLE;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         overflow_out <= 1'b0;
      end else if (start_ok) begin
         overflow_out <= 1'b0;
      end else if (drop || stray) begin
         overflow_out <= 1'b1;
      end
   end

   always_ff @(posedge clk_in) begin
      if (push) begin
         buf_q[wr_ptr] <= new_word;
      end
   end

   // head is re-registered every cycle so the port holds while stalled
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         cnt_q        <= '0;
         fb_valid_out <= 1'b0;
         fb_addr_out  <= '0;
         fb_data_out  <= '0;
      end else begin
         wr_ptr       <= wr_ptr + PW'(push);
         rd_ptr       <= rd_next;
         cnt_q        <= cnt_next;
         fb_valid_out <= (cnt_next != '0);
         if (cnt_left != '0) begin
            fb_addr_out <= buf_q[rd_next].addr;
            fb_data_out <= buf_q[rd_next].data;
         end else if (push) begin
            fb_addr_out <= new_word.addr;
            fb_data_out <= new_word.data;
         end
      end
   end

endmodule
